alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Decode/issue stage on the producer side of the integer ALU.
//  Accepts an instruction word plus register-file read data from fetch/regread over valid/ready.
//  Decodes OP, OP-IMM, LUI and AUIPC into ALU operands (a, b), funct3 op, mod bit and writeback control.
//  Presents them registered to the execute stage over valid/ready, through a 2-entry skid buffer.
// PARAMETERS
//  Width  32  datapath width; only 32 or 64 legal, anything else is an elaboration $error
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  rst_n        in   1      reset, asynchronous, active-low
//  flush        in   1      synchronous pipeline flush (branch/trap redirect)
//  in_valid     in   1      upstream holds a valid instruction
//  in_ready     out  1      stage can accept; registered, equals !skid_valid
//  in_instr     in   32     RV instruction word
//  in_pc        in   Width  instruction address
//  in_rs1_data  in   Width  rs1 read value
//  in_rs2_data  in   Width  rs2 read value
//  out_valid    out  1      decoded bundle valid
//  out_ready    in   1      execute stage accepts bundle
//  out_a        out  Width  ALU operand a
//  out_b        out  Width  ALU operand b
//  out_op       out  `ISA__FUNCT3_WIDTH  ALU op (funct3 encoding)
//  out_mod      out  1      ALU mod (SUB / SRA select)
//  out_rd       out  5      destination register
//  out_rd_we    out  1      writeback enable; forced 0 when rd==0 or illegal
//  out_pc       out  Width  pass-through PC
//  out_illegal  out  1      instruction not handled by this stage
// BEHAVIOUR
//  Reset: out_valid=0, in_ready=1, every data output 0, both entries empty; reset mid-transfer drops all contents.
//  Handshake: transfer when valid&&ready on the same edge.
//   - in_valid/in_* must stay stable until accepted; out_* stay stable while out_valid&&!out_ready.
//  Latency: accepted at edge N -> out_valid from edge N+1 when the stage is empty; strict FIFO order, no loss, no duplication.
//  Occupancy states (main, skid):
//   - EMPTY: on accept -> ONE.
//   - ONE: accept&&!drain -> TWO (new item into skid); drain&&!accept -> EMPTY; accept&&drain -> ONE (new item into main).
//   - TWO: in_ready=0, no accept; drain -> ONE (skid moves into main).
//  Flush: next state EMPTY, out_valid=0, in_ready=1; an input handshaking in the flush cycle is dropped; flush dominates drain and accept.
//  Decode, registered at capture; op field = in_instr[14:12]:
//   - OP (0110011): a=rs1, b=rs2. mod=instr[30] for ADD/SRL. funct7 must be 0x00, or 0x20 for ADD/SRL; else illegal.
//   - OP-IMM (0010011): a=rs1, b=sext(instr[31:20]).
//     - ADDI/SLTI/SLTIU/XORI/ORI/ANDI: mod=0 (instr[30] is an immediate bit).
//     - SLLI/SRLI/SRAI: b=zext(shamt), with shamt=instr[20+:$clog2(Width)]. mod=instr[30] for SRxI only.
//     - SLLI/SRLI/SRAI legality: the bits above shamt in instr[31:25] must be 0 (or 0x20-pattern for SRAI); else illegal.
//   - LUI (0110111): a=0, b=sext({instr[31:12],12'b0}), op=ADD, mod=0.
//   - AUIPC (0010111): a=pc, b as LUI, op=ADD, mod=0.
//   - Any other opcode, or instr[1:0]!=2'b11: illegal=1, rd_we=0, op=ADD, mod=0, a=b=0.
//  Arithmetic: all immediates sign-extended to Width except shamt (zero-extended); no truncation for Width=64.
// STRUCTURE
//  Shared in isa.svh: `ISA__OPCODE_OP/_OPIMM/_LUI/_AUIPC, `ISA__FUNCT7_BASE/_ALT, existing `ISA__FUNCT3_*.
//  Decoded-bundle struct typedef lives in isa.svh.
//  Sub-module: alu_issue_decode, purely combinational instr/pc/rs -> bundle.
//  This module holds only the main/skid registers and handshake logic.
// TESTING
//  - ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle: a=5, b=7, op=ADD, mod=0, rd=3, rd_we=1.
//  - SRAI x1,x2,4 (0x40415093) -> b=4, op=SRL, mod=1. ADDI x1,x0,-1 (0xFFF00093) -> b=0xFFFFFFFF, mod=0.
//  - XOR with funct7=0x20 (0x4020C1B3) -> illegal=1, rd_we=0. LUI x5,0x12345 (0x123452B7) -> a=0, b=0x12345000.
//  - out_ready=0, 3 back-to-back inputs -> first two accepted, in_ready=0 afterwards.
//    Then out_ready=1 -> all three delivered in order, none lost or duplicated.
//  - TWO occupancy + flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing later emitted.
//  - rst_n low mid-stream (asynchronous, between edges) -> out_valid=0 immediately; after release in_ready=1, outputs 0.

Source files
------------

// File: rtl/alu_issue_stage_pkg.sv
// Shared encodings for the ALU issue stage: RV opcodes, funct fields,
// the width-independent decoded control bundle and occupancy states.
package alu_issue_stage_pkg;

  localparam int FUNCT3_WIDTH = 3;

  localparam logic [6:0] OPCODE_OP    = 7'b0110011;
  localparam logic [6:0] OPCODE_OPIMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;

  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_ADD = 3'd0;
  localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_SLL = 3'd1;
  localparam logic [FUNCT3_WIDTH-1:0] FUNCT3_SRL = 3'd5;

  typedef struct packed {
    logic [FUNCT3_WIDTH-1:0] op;
    logic                    mod;
    logic [4:0]              rd;
    logic                    rd_we;
    logic                    illegal;
  } ctrl_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of OP, OP-IMM, LUI and AUIPC into ALU operands and
// writeback control; everything else is flagged illegal with zeroed operands.
module alu_issue_decode
  import alu_issue_stage_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic [31:0]      instr,
  input  logic [Width-1:0] pc,
  input  logic [Width-1:0] rs1_data,
  input  logic [Width-1:0] rs2_data,
  output logic [Width-1:0] a,
  output logic [Width-1:0] b,
  output ctrl_t            ctrl
);

  localparam int ShW = $clog2(Width);
  localparam int UpW = 12 - ShW;
  // Bits above shamt for SRAI carry only the instr[30] marker.
  localparam logic [UpW-1:0] UpAlt = {2'b01, {(UpW-2){1'b0}}};

  logic [6:0]        opcode;
  logic [6:0]        funct7;
  logic [2:0]        funct3;
  logic [UpW-1:0]    upper;
  logic signed [31:0] imm_u32;
  logic [Width-1:0]  imm_i;
  logic [Width-1:0]  imm_u;
  logic [Width-1:0]  shamt_z;
  logic              unused_rs1_field;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign upper   = instr[31 -: UpW];
  assign imm_u32 = {instr[31:12], 12'h000};
  assign imm_i   = {{(Width-12){instr[31]}}, instr[31:20]};
  assign imm_u   = Width'(imm_u32);
  assign shamt_z = Width'(instr[20 +: ShW]);
  assign unused_rs1_field = ^instr[19:15];

  always_comb begin
    a            = '0;
    b            = '0;
    ctrl.op      = FUNCT3_ADD;
    ctrl.mod     = 1'b0;
    ctrl.rd      = instr[11:7];
    ctrl.rd_we   = 1'b0;
    ctrl.illegal = 1'b1;
    if (instr[1:0] == 2'b11) begin
      case (opcode)
        OPCODE_OP: begin
          if (funct7 == FUNCT7_BASE ||
              (funct7 == FUNCT7_ALT && (funct3 == FUNCT3_ADD || funct3 == FUNCT3_SRL))) begin
            ctrl.illegal = 1'b0;
            a            = rs1_data;
            b            = rs2_data;
            ctrl.op      = funct3;
            ctrl.mod     = instr[30];
          end
        end
        OPCODE_OPIMM: begin
          case (funct3)
            FUNCT3_SLL: begin
              if (upper == '0) begin
                ctrl.illegal = 1'b0;
                a            = rs1_data;
                b            = shamt_z;
                ctrl.op      = funct3;
              end
            end
            FUNCT3_SRL: begin
              if (upper == '0 || upper == UpAlt) begin
                ctrl.illegal = 1'b0;
                a            = rs1_data;
                b            = shamt_z;
                ctrl.op      = funct3;
                ctrl.mod     = instr[30];
              end
            end
            default: begin
              ctrl.illegal = 1'b0;
              a            = rs1_data;
              b            = imm_i;
              ctrl.op      = funct3;
            end
          endcase
        end
        OPCODE_LUI: begin
          ctrl.illegal = 1'b0;
          b            = imm_u;
        end
        OPCODE_AUIPC: begin
          ctrl.illegal = 1'b0;
          a            = pc;
          b            = imm_u;
        end
        default: ;
      endcase
    end
    ctrl.rd_we = !ctrl.illegal && (ctrl.rd != 5'd0);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes at capture and holds results in a main register
// plus one skid register so in_ready depends only on stored state.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [Width-1:0]        in_pc,
  input  logic [Width-1:0]        in_rs1_data,
  input  logic [Width-1:0]        in_rs2_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [Width-1:0]        out_a,
  output logic [Width-1:0]        out_b,
  output logic [FUNCT3_WIDTH-1:0] out_op,
  output logic                    out_mod,
  output logic [4:0]              out_rd,
  output logic                    out_rd_we,
  output logic [Width-1:0]        out_pc,
  output logic                    out_illegal
);

  if (Width != 32 && Width != 64) begin : g_bad_width
    $error("alu_issue_stage: Width must be 32 or 64");
  end

  logic [Width-1:0] dec_a, dec_b;
  ctrl_t            dec_ctrl;

  alu_issue_decode #(.Width(Width)) u_decode (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .a        (dec_a),
    .b        (dec_b),
    .ctrl     (dec_ctrl)
  );

  // Handshake: a beat moves on any rising edge where valid && ready; the
  // producer holds valid and data until then, flush drops whatever is held.
  occ_e occ, occ_next;
  logic accept, drain;
  logic load_main_in, load_main_skid, load_skid;

  logic [Width-1:0] main_a, main_b, main_pc, skid_a, skid_b, skid_pc;
  ctrl_t            main_ctrl, skid_ctrl;

  assign in_ready  = (occ != OCC_TWO);
  assign out_valid = (occ != OCC_EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ <= OCC_EMPTY;
    else        occ <= occ_next;
  end

  always_comb begin
    occ_next       = occ;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      occ_next = OCC_EMPTY;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (accept) begin
            occ_next     = OCC_ONE;
            load_main_in = 1'b1;
          end
        end
        OCC_ONE: begin
          if (accept && !drain) begin
            occ_next  = OCC_TWO;
            load_skid = 1'b1;
          end else if (drain && !accept) begin
            occ_next = OCC_EMPTY;
          end else if (accept && drain) begin
            load_main_in = 1'b1;
          end
        end
        OCC_TWO: begin
          if (drain) begin
            occ_next       = OCC_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: occ_next = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_a    <= '0;
      main_b    <= '0;
      main_pc   <= '0;
      main_ctrl <= '0;
      skid_a    <= '0;
      skid_b    <= '0;
      skid_pc   <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main_in) begin
        main_a    <= dec_a;
        main_b    <= dec_b;
        main_pc   <= in_pc;
        main_ctrl <= dec_ctrl;
      end else if (load_main_skid) begin
        main_a    <= skid_a;
        main_b    <= skid_b;
        main_pc   <= skid_pc;
        main_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_a    <= dec_a;
        skid_b    <= dec_b;
        skid_pc   <= in_pc;
        skid_ctrl <= dec_ctrl;
      end
    end
  end

  assign out_a       = main_a;
  assign out_b       = main_b;
  assign out_pc      = main_pc;
  assign out_op      = main_ctrl.op;
  assign out_mod     = main_ctrl.mod;
  assign out_rd      = main_ctrl.rd;
  assign out_rd_we   = main_ctrl.rd_we;
  assign out_illegal = main_ctrl.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed decode vectors, skid/backpressure,
// flush, async reset and a randomized run against a queue-based model.
module tb_alu_issue_stage;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] pc;
    logic [2:0]   op;
    logic         mod;
    logic [4:0]   rd;
    logic         rd_we;
    logic         ill;
  } exp_t;

  localparam int BW = $bits(exp_t);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_instr = '0;
  logic [W-1:0] in_pc = '0;
  logic [W-1:0] in_rs1_data = '0;
  logic [W-1:0] in_rs2_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_a, out_b, out_pc;
  logic [2:0]   out_op;
  logic         out_mod, out_rd_we, out_illegal;
  logic [4:0]   out_rd;

  int tests_run = 0;
  int tests_failed = 0;
  logic [BW-1:0] exp_q[$];

  alu_issue_stage #(.Width(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_mod(out_mod),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_pc(out_pc),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference decoder written directly from the RV32 instruction rules.
  function automatic exp_t ref_decode(input logic [31:0] instr, input logic [W-1:0] pc,
                                      input logic [W-1:0] rs1, input logic [W-1:0] rs2);
    exp_t e;
    logic [6:0] f7;
    logic [2:0] f3;
    e = '0;
    e.pc = pc;
    e.rd = instr[11:7];
    e.ill = 1'b1;
    f7 = instr[31:25];
    f3 = instr[14:12];
    case (instr[6:0])
      7'h33: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
        e.ill = 1'b0; e.a = rs1; e.b = rs2; e.op = f3; e.mod = (f7 == 7'h20);
      end
      7'h13: begin
        if (f3 == 3'd1) begin
          if (f7 == 7'h00) begin
            e.ill = 1'b0; e.a = rs1; e.b = {27'd0, instr[24:20]}; e.op = 3'd1;
          end
        end else if (f3 == 3'd5) begin
          if (f7 == 7'h00 || f7 == 7'h20) begin
            e.ill = 1'b0; e.a = rs1; e.b = {27'd0, instr[24:20]}; e.op = 3'd5;
            e.mod = (f7 == 7'h20);
          end
        end else begin
          e.ill = 1'b0; e.a = rs1; e.b = {{20{instr[31]}}, instr[31:20]}; e.op = f3;
        end
      end
      7'h37: begin e.ill = 1'b0; e.b = {instr[31:12], 12'h000}; end
      7'h17: begin e.ill = 1'b0; e.a = pc; e.b = {instr[31:12], 12'h000}; end
      default: ;
    endcase
    e.rd_we = !e.ill && (e.rd != 5'd0);
    return e;
  endfunction

  function automatic exp_t dut_bundle();
    exp_t d;
    d = '{out_a, out_b, out_pc, out_op, out_mod, out_rd, out_rd_we, out_illegal};
    return d;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 5))
      0: begin
        w[6:0] = 7'h33;
        if ($urandom_range(0, 2) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      end
      1, 2: begin
        w[6:0] = 7'h13;
        if ($urandom_range(0, 2) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      end
      3: w[6:0] = 7'h37;
      4: w[6:0] = 7'h17;
      default: ;
    endcase
    return w;
  endfunction

  task automatic test_reset();
    exp_t got;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    got = dut_bundle();
    tests_run++;
    if (got !== '0) begin
      tests_failed++; $display("FAIL reset_outputs: got %h expected 0", got);
    end
  endtask

  task automatic test_decode();
    logic [31:0]  vi[9];
    logic [W-1:0] vr1[9], vr2[9], vpc[9];
    exp_t         ve[9];
    exp_t         got, mdl;
    vi[0] = 32'h002081B3; vpc[0] = 32'h100;  vr1[0] = 32'd5;        vr2[0] = 32'd7;
    ve[0] = '{32'd5, 32'd7, 32'h100, 3'd0, 1'b0, 5'd3, 1'b1, 1'b0};
    vi[1] = 32'h40415093; vpc[1] = 32'h104;  vr1[1] = 32'h80000000; vr2[1] = 32'd0;
    ve[1] = '{32'h80000000, 32'd4, 32'h104, 3'd5, 1'b1, 5'd1, 1'b1, 1'b0};
    vi[2] = 32'hFFF00093; vpc[2] = 32'h108;  vr1[2] = 32'd0;        vr2[2] = 32'd0;
    ve[2] = '{32'd0, 32'hFFFFFFFF, 32'h108, 3'd0, 1'b0, 5'd1, 1'b1, 1'b0};
    vi[3] = 32'h4020C1B3; vpc[3] = 32'h10C;  vr1[3] = 32'hAAAA;     vr2[3] = 32'h5555;
    ve[3] = '{32'd0, 32'd0, 32'h10C, 3'd0, 1'b0, 5'd3, 1'b0, 1'b1};
    vi[4] = 32'h123452B7; vpc[4] = 32'h110;  vr1[4] = 32'd9;        vr2[4] = 32'd9;
    ve[4] = '{32'd0, 32'h12345000, 32'h110, 3'd0, 1'b0, 5'd5, 1'b1, 1'b0};
    vi[5] = 32'hFFFFF017; vpc[5] = 32'h1000; vr1[5] = 32'd1;        vr2[5] = 32'd2;
    ve[5] = '{32'h1000, 32'hFFFFF000, 32'h1000, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0};
    vi[6] = 32'h002081B1; vpc[6] = 32'h114;  vr1[6] = 32'd5;        vr2[6] = 32'd7;
    ve[6] = '{32'd0, 32'd0, 32'h114, 3'd0, 1'b0, 5'd3, 1'b0, 1'b1};
    vi[7] = 32'h02209093; vpc[7] = 32'h118;  vr1[7] = 32'd3;        vr2[7] = 32'd0;
    ve[7] = '{32'd0, 32'd0, 32'h118, 3'd0, 1'b0, 5'd1, 1'b0, 1'b1};
    vi[8] = 32'h402081B3; vpc[8] = 32'h11C;  vr1[8] = 32'd10;       vr2[8] = 32'd3;
    ve[8] = '{32'd10, 32'd3, 32'h11C, 3'd0, 1'b1, 5'd3, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      in_instr = vi[i]; in_pc = vpc[i]; in_rs1_data = vr1[i]; in_rs2_data = vr2[i];
      in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++; $display("FAIL decode%0d_in_ready: got %b expected 1", i, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1) begin
        tests_failed++; $display("FAIL decode%0d_latency: out_valid got %b expected 1", i, out_valid);
      end
      got = dut_bundle();
      tests_run++;
      if (got !== ve[i]) begin
        tests_failed++; $display("FAIL decode%0d_fields: got %h expected %h", i, got, ve[i]);
      end
      mdl = ref_decode(vi[i], vpc[i], vr1[i], vr2[i]);
      tests_run++;
      if (got !== mdl) begin
        tests_failed++; $display("FAIL decode%0d_model: got %h expected %h", i, got, mdl);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++; $display("FAIL decode%0d_drained: out_valid got %b expected 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t got;
    int   delivered;
    logic acc;
    exp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_instr = rand_instr(); in_pc = $urandom(); in_rs1_data = $urandom(); in_rs2_data = $urandom();
      in_valid = 1'b1;
      @(negedge clk);
      tests_run++;
      if (in_ready !== (i < 2)) begin
        tests_failed++; $display("FAIL b2b_in_ready%0d: got %b expected %b", i, in_ready, (i < 2));
      end
      if (in_ready) exp_q.push_back(ref_decode(in_instr, in_pc, in_rs1_data, in_rs2_data));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    delivered = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got = dut_bundle();
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++; $display("FAIL b2b_extra_output: got %h expected none", got);
        end else begin
          if (got !== exp_t'(exp_q[0])) begin
            tests_failed++; $display("FAIL b2b_order%0d: got %h expected %h", delivered, got, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        delivered++;
      end
      acc = in_valid && in_ready;
      if (acc) exp_q.push_back(ref_decode(in_instr, in_pc, in_rs1_data, in_rs2_data));
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    tests_run++;
    if (delivered != 3) begin
      tests_failed++; $display("FAIL b2b_count: got %0d expected 3", delivered);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL b2b_leftover: got %0d expected 0", exp_q.size());
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    int   seen;
    exp_t got, e;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      in_instr = rand_instr(); in_pc = $urandom(); in_rs1_data = $urandom(); in_rs2_data = $urandom();
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_instr = 32'h002081B3;
    flush = 1'b1;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL flush_two_state: in_ready got %b expected 0", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL flush_out_valid: got %b expected 0", out_valid);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL flush_in_ready: got %b expected 1", in_ready);
    end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++; $display("FAIL flush_no_emit: got %0d outputs expected 0", seen);
    end
    @(posedge clk); #1;
    in_instr = 32'h00500093; in_pc = 32'h200; in_rs1_data = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    got = dut_bundle();
    e = '{32'd1, 32'd5, 32'h200, 3'd0, 1'b0, 5'd1, 1'b1, 1'b0};
    tests_run++;
    if (out_valid !== 1'b1 || got !== e) begin
      tests_failed++; $display("FAIL flush_recover: got v=%b %h expected v=1 %h", out_valid, got, e);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic consumed;
    logic acc;
    int   ncyc;
    exp_t got;
    exp_q.delete();
    consumed = 1'b1;
    ncyc = 400;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (c >= ncyc - 12) begin
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      end else begin
        if (consumed) begin
          in_valid = ($urandom_range(0, 3) != 0);
          in_instr = rand_instr(); in_pc = $urandom();
          in_rs1_data = $urandom(); in_rs2_data = $urandom();
        end
        out_ready = ($urandom_range(0, 3) != 0);
        flush = ($urandom_range(0, 29) == 0);
      end
      @(negedge clk);
      tests_run++;
      if (out_valid !== (exp_q.size() != 0)) begin
        tests_failed++; $display("FAIL rand_out_valid c%0d: got %b expected %b", c, out_valid, exp_q.size() != 0);
      end
      tests_run++;
      if (in_ready !== (exp_q.size() < 2)) begin
        tests_failed++; $display("FAIL rand_in_ready c%0d: got %b expected %b", c, in_ready, exp_q.size() < 2);
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        got = dut_bundle();
        tests_run++;
        if (got !== exp_t'(exp_q[0])) begin
          tests_failed++; $display("FAIL rand_data c%0d: got %h expected %h", c, got, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      acc = in_valid && in_ready;
      if (flush) exp_q.delete();
      else if (acc) exp_q.push_back(ref_decode(in_instr, in_pc, in_rs1_data, in_rs2_data));
      consumed = acc || flush || !in_valid;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL rand_leftover: got %0d expected 0", exp_q.size());
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t got;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      in_instr = 32'h002081B3; in_pc = 32'h300 + i; in_rs1_data = 32'd11; in_rs2_data = 32'd22;
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL async_reset_out_valid: got %b expected 0", out_valid);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL async_reset_in_ready: got %b expected 1", in_ready);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    got = dut_bundle();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || got !== '0) begin
      tests_failed++;
      $display("FAIL async_reset_release: got v=%b r=%b %h expected v=0 r=1 0", out_valid, in_ready, got);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
